apb_dual_master_arbiter: RTL
============================

Name: apb_dual_master_arbiter

Overview:
- Two-port APB master that shares the single APB memory slave between two local requesters (e.g. a DMA engine and a host bridge).
- Arbitrates round-robin and sequences each transfer through standard APB SETUP/ACCESS phases.
- Range-checks addresses against the slave memory depth and bounds wait states with a timeout.
- Returns one response per accepted request to the requester that was granted.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and requester data.
- ADDR_WIDTH, 12, width of PADDR and requester address.
- MEM_DEPTH, 1024, number of valid slave words; addresses >= MEM_DEPTH are rejected.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for PREADY before abort (must be >= 2).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous, active-high reset
- reqN_valid  in  1  requester N (N=0,1) has a transfer pending
- reqN_ready  out  1  requester N transfer accepted this cycle
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  one-cycle response strobe to requester N
- rspN_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rspN_err  out  1  1=out-of-range or timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Reset (PRESET=1, async):
  - state=IDLE; all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0.
  - grant = the single valid requester. If both are valid, grant = the requester != last_grant.
  - reqN_ready is combinational: (state==IDLE) && (grant==N) && reqN_valid.
  - On accept: latch write/addr/wdata and grant index; last_grant <= grant.
  - If addr >= MEM_DEPTH: go to RESP with err=1, rdata=0. No APB activity.
  - Otherwise: go to SETUP and load PADDR/PWRITE/PWDATA.
- SETUP:
  - PSEL=1, PENABLE=0; exactly one cycle, then ACCESS.
  - Wait counter cleared.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - PREADY=1: capture PRDATA for reads (0 for writes), err=0, go to RESP, deassert PSEL/PENABLE.
  - PREADY=0: counter++. When counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: err=1, rdata=0, go to RESP, deassert PSEL/PENABLE.
- PREADY is sampled only in ACCESS. A high PREADY in IDLE/SETUP is ignored.
- RESP:
  - rspG_valid=1 for exactly one cycle with rdata/err, to the granted requester only. The other rsp port stays 0.
  - Next state IDLE. No response back-pressure.
- PADDR/PWDATA/PWRITE hold their last values while idle (0 after reset).
- Requester rules:
  - A requester holds valid and its fields stable until ready.
  - Deasserting valid before ready is legal and has no effect.
  - A new request is only accepted in IDLE, so at most one transfer is in flight.
- Latency: accept -> SETUP next cycle. Minimum accept-to-rsp_valid = 3 cycles with zero wait states; min 4 cycles per transfer including IDLE.
- Round-robin: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Write 0xDEADBEEF to addr 0x010 via req0, then read 0x010 -> PSEL for 1 cycle before PENABLE; PADDR=0x010 stable through ACCESS; rsp0_valid once with err=0; read returns 0xDEADBEEF; rsp1_valid never asserted.
- req0 and req1 both held valid for 4 transfers from reset -> grant order 0,1,0,1; each rsp arrives only on the matching port.
- req1 read at addr 0x400 (MEM_DEPTH=1024) -> PSEL stays 0; rsp1_valid 1 cycle after accept with err=1, rdata=0.
- Stub slave holds PREADY=0, TIMEOUT_CYCLES=16 -> exactly 16 cycles of PENABLE=1, then PSEL/PENABLE drop; rsp err=1, rdata=0.
- PRESET pulsed mid-ACCESS -> PSEL/PENABLE go to 0 asynchronously; no rsp_valid; a later req0 read completes normally with err=0.
- PREADY tied 1 at all times -> ACCESS lasts exactly 1 cycle; rsp_valid 3 cycles after accept; PENABLE never asserted without a preceding SETUP cycle.

Source files
------------

// File: rtl/apb_dual_master_arbiter.sv
// apb_dual_master_arbiter: round-robin APB master shared by two local requesters,
// with address range checking and a bounded ACCESS-phase wait.
module apb_dual_master_arbiter #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 12,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t                state, state_n;
    logic                  last_grant, gnt, grant, g_n, accept, in_range, timeout, res_err;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, res_rdata;
    logic [CW-1:0]         cnt;
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_write  = grant ? req1_write : req0_write;
        sel_addr   = grant ? req1_addr : req0_addr;
        sel_wdata  = grant ? req1_wdata : req0_wdata;
        accept     = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        in_range   = 32'(sel_addr) < MEM_DEPTH;
        timeout    = cnt == CW'(TIMEOUT_CYCLES - 1);
        g_n        = accept ? grant : gnt;
        state_n    = state;
        res_err    = 1'b0;
        res_rdata  = '0;
        case (state)
            IDLE: begin
                state_n = accept ? (in_range ? SETUP : RESP) : IDLE;
                res_err = accept && !in_range;
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                state_n   = (PREADY || timeout) ? RESP : ACCESS;
                res_err   = !PREADY;
                res_rdata = (PREADY && !PWRITE) ? PRDATA : '0;
            end
            default: state_n = IDLE;
        endcase
    end
    // APB and response outputs are registered from the next state so they never glitch.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            cnt        <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= (state == ACCESS) ? cnt + 1'b1 : '0;
            PSEL       <= (state_n == SETUP) || (state_n == ACCESS);
            PENABLE    <= state_n == ACCESS;
            rsp0_valid <= (state_n == RESP) && !g_n;
            rsp0_rdata <= ((state_n == RESP) && !g_n) ? res_rdata : '0;
            rsp0_err   <= (state_n == RESP) && !g_n && res_err;
            rsp1_valid <= (state_n == RESP) && g_n;
            rsp1_rdata <= ((state_n == RESP) && g_n) ? res_rdata : '0;
            rsp1_err   <= (state_n == RESP) && g_n && res_err;
            if (accept) begin
                gnt        <= grant;
                last_grant <= grant;
            end
            if (accept && in_range) begin
                PWRITE <= sel_write;
                PADDR  <= sel_addr;
                PWDATA <= sel_wdata;
            end
        end
    end
endmodule
